// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller.
// Holds the instruction class encodings, the operand-select encodings that
// the existing datapath already decodes, and the controller state type.
package alu_seq_ctrl_pkg;

  localparam int OP_CLASS_W = 3;

  localparam logic [OP_CLASS_W-1:0] OP_R     = 3'd0;
  localparam logic [OP_CLASS_W-1:0] OP_I     = 3'd1;
  localparam logic [OP_CLASS_W-1:0] OP_LOAD  = 3'd2;
  localparam logic [OP_CLASS_W-1:0] OP_STORE = 3'd3;
  localparam logic [OP_CLASS_W-1:0] OP_JAL   = 3'd4;

  localparam int ALU_SRC_SIZE = 2;

  // These values feed the existing operand mux; do not renumber.
  localparam logic [ALU_SRC_SIZE-1:0] ALU_SRC_IMM       = 2'd0;
  localparam logic [ALU_SRC_SIZE-1:0] ALU_SRC_RD2       = 2'd1;
  localparam logic [ALU_SRC_SIZE-1:0] ALU_SRC_PC_PLUS_4 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Classes 5..7 are unassigned and rejected at the handshake.
  function automatic logic op_legal(input logic [OP_CLASS_W-1:0] op);
    return (op <= OP_JAL);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction handshake, memory handshake and control strobes of the ALU
// sequencing controller.
//   slave  : controller side (accepts instructions, issues strobes)
//   master : decoder/memory side (issues instructions, answers mem_req)
interface alu_seq_ctrl_if;
  import alu_seq_ctrl_pkg::*;

  logic                    instr_valid;
  logic                    instr_ready;
  logic [OP_CLASS_W-1:0]   op_class;
  logic [ALU_SRC_SIZE-1:0] alu_src2;
  logic                    alu_en;
  logic                    mem_req;
  logic                    mem_we;
  logic                    mem_ack;
  logic                    rf_we;
  logic                    pc_we;
  logic                    retire;
  logic                    mem_err;
  logic                    illegal;
  logic                    busy;

  modport slave (
    input  instr_valid, op_class, mem_ack,
    output instr_ready, alu_src2, alu_en, mem_req, mem_we,
           rf_we, pc_we, retire, mem_err, illegal, busy
  );

  modport master (
    output instr_valid, op_class, mem_ack,
    input  instr_ready, alu_src2, alu_en, mem_req, mem_we,
           rf_we, pc_we, retire, mem_err, illegal, busy
  );

endinterface

// File: rtl/alu_seq_timeout.sv
// MEM-state wait counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to zero (held while not in MEM)
//   en         : count one cycle of waiting for mem_ack
//   expired    : count has reached MEM_TIMEOUT-1
module alu_seq_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Saturates at the terminal value so a count can never wrap within one visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencing controller: accepts one decoded instruction class at a time
// and walks it through execute, optional memory access and writeback.
//   clk, rst_n : clock, async active-low reset
//   bus        : alu_seq_ctrl_if.slave (instruction/memory handshake, strobes)
//
// state | meaning
// IDLE  | ready for an instruction; illegal classes are rejected here
// EXEC  | one ALU cycle, operand select by latched class
// MEM   | LOAD/STORE access, mem_req held until mem_ack or timeout
// WB    | retire: pc update, register write except STORE
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_ctrl_if.slave bus
);

  state_e                state, state_nxt;
  logic [OP_CLASS_W-1:0] cls_q;
  logic                  mem_err_q;
  logic                  illegal_q;
  logic                  expired;
  logic                  hs;
  logic                  is_mem_op;

  assign hs        = (state == ST_IDLE) && bus.instr_valid;
  assign is_mem_op = (cls_q == OP_LOAD) || (cls_q == OP_STORE);

  alu_seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != ST_MEM),
    .en      ((state == ST_MEM) && !bus.mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cls_q     <= OP_R;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (hs && op_legal(bus.op_class)) begin
        cls_q <= bus.op_class;
      end
      illegal_q <= hs && !op_legal(bus.op_class);
      mem_err_q <= (state == ST_MEM) && expired && !bus.mem_ack;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.alu_en      = 1'b0;
    bus.alu_src2    = ALU_SRC_RD2;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.rf_we       = 1'b0;
    bus.pc_we       = 1'b0;
    bus.retire      = 1'b0;
    bus.busy        = 1'b1;
    bus.mem_err     = mem_err_q;
    bus.illegal     = illegal_q;
    unique case (state)
      ST_IDLE: begin
        bus.instr_ready = 1'b1;
        bus.busy        = 1'b0;
        if (hs && op_legal(bus.op_class)) begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        bus.alu_en = 1'b1;
        if (cls_q == OP_R) begin
          bus.alu_src2 = ALU_SRC_RD2;
        end else if (cls_q == OP_JAL) begin
          bus.alu_src2 = ALU_SRC_PC_PLUS_4;
        end else begin
          bus.alu_src2 = ALU_SRC_IMM;
        end
        state_nxt = is_mem_op ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        // Immediate operand held so the computed address stays stable.
        bus.alu_en   = 1'b1;
        bus.alu_src2 = ALU_SRC_IMM;
        bus.mem_req  = 1'b1;
        bus.mem_we   = (cls_q == OP_STORE);
        // An ack on the terminal cycle still completes the access.
        if (bus.mem_ack) begin
          state_nxt = ST_WB;
        end else if (expired) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        bus.pc_we  = 1'b1;
        bus.retire = 1'b1;
        bus.rf_we  = (cls_q != OP_STORE);
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam logic [2:0] K_RET = 3'b001;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_ILL = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         lat;
    logic [1:0] src;
    int         memn;
    logic       we;
    logic       rf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_ctrl_if bus();

  alu_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] kind, input int lat, input logic [1:0] src,
                              input int memn, input logic we, input logic rf);
    exp_t e;
    e.kind = kind; e.lat = lat; e.src = src; e.memn = memn; e.we = we; e.rf = rf;
    return e;
  endfunction

  // Monitor: tracks the in-flight instruction and scores each completion event.
  bit         active = 0;
  int         cyc_in = 0;
  int         memn = 0;
  logic [1:0] ex_src = 2'd0;
  logic       ex_en = 1'b0;
  logic       we_seen = 1'b0;
  logic       src_bad = 1'b0;

  always @(negedge clk) begin
    logic [2:0] ev;
    exp_t e;
    if (!rst_n) begin
      active = 0;
    end else begin
      chk("busy_vs_ready", int'(bus.busy), int'(!bus.instr_ready));
      if (active) begin
        cyc_in++;
        if (cyc_in == 1) begin
          ex_src = bus.alu_src2;
          ex_en  = bus.alu_en;
        end
        if (bus.mem_req) begin
          memn++;
          if (bus.alu_src2 != ALU_SRC_IMM || !bus.alu_en) src_bad = 1'b1;
          if (bus.mem_we) we_seen = 1'b1;
        end
      end
      ev = {bus.illegal, bus.mem_err, bus.retire};
      if (ev != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", int'(ev), 0);
        end else begin
          e = sb.pop_front();
          chk("event_kind", int'(ev), int'(e.kind));
          chk("latency", cyc_in, e.lat);
          if (e.kind != K_ILL) chk("exec_src", int'(ex_src), int'(e.src));
          chk("exec_alu_en", int'(ex_en), int'(e.kind != K_ILL));
          chk("mem_cycles", memn, e.memn);
          chk("mem_we", int'(we_seen), int'(e.we));
          chk("mem_src_imm", int'(src_bad), 0);
          chk("rf_we", int'(bus.rf_we), int'(e.rf));
          chk("pc_we", int'(bus.pc_we), int'(e.kind == K_RET));
        end
        active = 0;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        active  = 1;
        cyc_in  = 0;
        memn    = 0;
        we_seen = 1'b0;
        src_bad = 1'b0;
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"},   int'(bus.instr_ready), 1);
    chk({tag, "_src2"},    int'(bus.alu_src2), int'(ALU_SRC_RD2));
    chk({tag, "_alu_en"},  int'(bus.alu_en), 0);
    chk({tag, "_mem_req"}, int'(bus.mem_req), 0);
    chk({tag, "_mem_we"},  int'(bus.mem_we), 0);
    chk({tag, "_strobes"}, int'({bus.rf_we, bus.pc_we, bus.retire}), 0);
    chk({tag, "_mem_err"}, int'(bus.mem_err), 0);
    chk({tag, "_illegal"}, int'(bus.illegal), 0);
    chk({tag, "_busy"},    int'(bus.busy), 0);
  endtask

  // Issue one instruction, answer mem_req with an ack on MEM cycle ack_on
  // (0 = never), optionally drive mem_ack high outside MEM, then drain.
  task automatic send(input logic [2:0] op, input int ack_on, input logic noise, input exp_t e);
    int mc;
    bit done;
    mc = 0;
    done = 0;
    sb.push_back(e);
    bus.instr_valid = 1'b1;
    bus.op_class    = op;
    bus.mem_ack     = noise;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    bus.op_class    = op ^ 3'b001;
    chk("busy_after_hs", int'(bus.busy), int'(e.kind != K_ILL));
    for (int i = 0; i < 64; i++) begin
      if (!bus.busy) begin
        done = 1;
        break;
      end
      if (bus.mem_req) begin
        mc++;
        bus.mem_ack = (mc == ack_on);
      end else begin
        bus.mem_ack = noise;
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
    chk("drain_done", int'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.op_class    = OP_R;
    bus.mem_ack     = 1'b0;
    #2;
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(OP_R,     0,  1'b1, mk(K_RET, 2,  ALU_SRC_RD2,       0,  1'b0, 1'b1));
    send(OP_I,     0,  1'b0, mk(K_RET, 2,  ALU_SRC_IMM,       0,  1'b0, 1'b1));
    send(OP_LOAD,  3,  1'b1, mk(K_RET, 5,  ALU_SRC_IMM,       3,  1'b0, 1'b1));
    send(OP_STORE, 1,  1'b0, mk(K_RET, 3,  ALU_SRC_IMM,       1,  1'b1, 1'b0));
    send(OP_JAL,   0,  1'b0, mk(K_RET, 2,  ALU_SRC_PC_PLUS_4, 0,  1'b0, 1'b1));
    send(3'd6,     0,  1'b0, mk(K_ILL, 1,  ALU_SRC_RD2,       0,  1'b0, 1'b0));
    send(3'd5,     0,  1'b0, mk(K_ILL, 1,  ALU_SRC_RD2,       0,  1'b0, 1'b0));
    send(3'd7,     0,  1'b0, mk(K_ILL, 1,  ALU_SRC_RD2,       0,  1'b0, 1'b0));
    send(OP_STORE, 0,  1'b0, mk(K_ERR, 18, ALU_SRC_IMM,       16, 1'b1, 1'b0));
    send(OP_LOAD,  16, 1'b0, mk(K_RET, 18, ALU_SRC_IMM,       16, 1'b0, 1'b1));
    send(OP_LOAD,  15, 1'b0, mk(K_RET, 17, ALU_SRC_IMM,       15, 1'b0, 1'b1));

    // Reset on the second MEM cycle of a LOAD: no completion event may follow.
    bus.instr_valid = 1'b1;
    bus.op_class    = OP_LOAD;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_mem_req", int'(bus.mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_mem_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_idle_outputs("post_reset");

    send(OP_R,     0,  1'b0, mk(K_RET, 2,  ALU_SRC_RD2,       0,  1'b0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
